// File: rtl/conv_kxk_stream_if.sv
// Pixel stream, weight-load port and result bus of the KxK convolution layer.
// master drives pixels and weights; slave is the convolution core.
interface conv_kxk_stream_if #(
  parameter int DATA_BIT   = 8,
  parameter int WEIGHT_BIT = 8,
  parameter int OUT_CH     = 3,
  parameter int OUT_BIT    = 12,
  parameter int AW         = 7
);
  logic                      in_valid;
  logic [DATA_BIT-1:0]       in_data;
  logic                      w_we;
  logic [AW-1:0]             w_addr;
  logic [WEIGHT_BIT-1:0]     w_data;
  logic [OUT_CH*OUT_BIT-1:0] conv_out;
  logic                      out_valid;
  logic                      out_last;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data,
    input  conv_out, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data,
    output conv_out, out_valid, out_last
  );
endinterface

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution, OUT_CH channels; result 3 cycles after the window-completing pixel.
// No backpressure: the pipeline never stalls, in_valid gaps only freeze counters, line buffers and window.
module conv_kxk_stream #(
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int DATA_BIT   = 8,
  parameter int KSIZE      = 5,
  parameter int OUT_CH     = 3,
  parameter int WEIGHT_BIT = 8,
  parameter int OUT_BIT    = 12,
  parameter int SHIFT      = 8
) (
  input logic              clk,
  input logic              rst,
  conv_kxk_stream_if.slave bus
);
  localparam int TAPS  = KSIZE * KSIZE;
  localparam int NW    = OUT_CH * TAPS + OUT_CH;
  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int PW    = DATA_BIT + WEIGHT_BIT + 1;
  localparam int ACC_W = DATA_BIT + WEIGHT_BIT + $clog2(TAPS) + 1;
  localparam int SW    = ACC_W + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((1 <<< (OUT_BIT - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(1 <<< (OUT_BIT - 1)));

  logic [CW-1:0]                  col_q, col_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [DATA_BIT-1:0]            lb_q    [KSIZE-1][WIDTH];
  logic [DATA_BIT-1:0]            win_q   [TAPS];
  logic [DATA_BIT-1:0]            col_pix [KSIZE];
  logic signed [WEIGHT_BIT-1:0]   wt_q    [NW];
  logic signed [PW-1:0]           prod_q  [OUT_CH][TAPS];
  logic signed [PW-1:0]           prod_d  [OUT_CH][TAPS];
  logic signed [SW-1:0]           sum_q   [OUT_CH];
  logic signed [SW-1:0]           sum_d   [OUT_CH];
  logic signed [SW-1:0]           shf;
  logic [OUT_CH*OUT_BIT-1:0]      conv_out_q, conv_out_d;
  logic                           win_vld, win_last;
  logic                           v1_q, v2_q, v3_q, out_valid_q;
  logic                           l1_q, l2_q, l3_q, out_last_q;

  // Raster position of the pixel currently presented on in_data.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (col_q == CW'(WIDTH - 1)) begin
      col_d = '0;
      row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  assign win_vld  = bus.in_valid && (row_q >= RW'(KSIZE - 1)) && (col_q >= CW'(KSIZE - 1));
  assign win_last = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));

  // Column entering the window: bottom row is the live pixel, row r is (KSIZE-1-r) lines back.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) col_pix[r] = '0;
    col_pix[KSIZE-1] = bus.in_data;
    for (int r = 0; r < KSIZE - 1; r++) col_pix[r] = lb_q[KSIZE-2-r][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      for (int j = 0; j < KSIZE - 1; j++)
        for (int i = 0; i < WIDTH; i++) lb_q[j][i] <= '0;
      for (int t = 0; t < TAPS; t++) win_q[t] <= '0;
    end else if (bus.in_valid) begin
      col_q <= col_d;
      row_q <= row_d;
      lb_q[0][0] <= bus.in_data;
      for (int j = 1; j < KSIZE - 1; j++) lb_q[j][0] <= lb_q[j-1][WIDTH-1];
      for (int j = 0; j < KSIZE - 1; j++)
        for (int i = 1; i < WIDTH; i++) lb_q[j][i] <= lb_q[j][i-1];
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) win_q[r*KSIZE+c] <= win_q[r*KSIZE+c+1];
        win_q[r*KSIZE+KSIZE-1] <= col_pix[r];
      end
    end
  end

  // Weights at ch*TAPS+idx, biases at OUT_CH*TAPS+ch; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NW; a++) wt_q[a] <= '0;
    end else if (bus.w_we && (int'(bus.w_addr) < NW)) begin
      wt_q[bus.w_addr] <= bus.w_data;
    end
  end

  always_comb begin
    for (int ch = 0; ch < OUT_CH; ch++)
      for (int t = 0; t < TAPS; t++)
        prod_d[ch][t] = PW'($signed({1'b0, win_q[t]})) * PW'(wt_q[ch*TAPS+t]);
  end

  always_comb begin
    for (int ch = 0; ch < OUT_CH; ch++) begin
      sum_d[ch] = SW'(wt_q[OUT_CH*TAPS+ch]);
      for (int t = 0; t < TAPS; t++) sum_d[ch] = sum_d[ch] + SW'(prod_q[ch][t]);
    end
  end

  // Floor shift then clamp; conv_out only changes on a valid result.
  always_comb begin
    conv_out_d = conv_out_q;
    shf        = '0;
    for (int ch = 0; ch < OUT_CH; ch++) begin
      shf = sum_q[ch] >>> SHIFT;
      if (v3_q) begin
        if (shf > MAXV)      conv_out_d[ch*OUT_BIT +: OUT_BIT] = OUT_BIT'(MAXV);
        else if (shf < MINV) conv_out_d[ch*OUT_BIT +: OUT_BIT] = OUT_BIT'(MINV);
        else                 conv_out_d[ch*OUT_BIT +: OUT_BIT] = OUT_BIT'(shf);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < OUT_CH; ch++) begin
        for (int t = 0; t < TAPS; t++) prod_q[ch][t] <= '0;
        sum_q[ch] <= '0;
      end
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      l3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      conv_out_q  <= '0;
    end else begin
      prod_q      <= prod_d;
      sum_q       <= sum_d;
      v1_q        <= win_vld;
      l1_q        <= win_vld && win_last;
      v2_q        <= v1_q;
      l2_q        <= l1_q;
      v3_q        <= v2_q;
      l3_q        <= l2_q;
      out_valid_q <= v3_q;
      out_last_q  <= v3_q && l3_q;
      conv_out_q  <= conv_out_d;
    end
  end

  assign bus.conv_out  = conv_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv_kxk_stream.sv
// Random-stimulus bench for conv_kxk_stream: direct-sum reference model feeds a scoreboard
// queue; a negedge monitor checks value, out_last, latency and hold behaviour.
module tb_conv_kxk_stream;
  localparam int WIDTH      = 28;
  localparam int HEIGHT     = 28;
  localparam int DATA_BIT   = 8;
  localparam int KSIZE      = 5;
  localparam int OUT_CH     = 3;
  localparam int WEIGHT_BIT = 8;
  localparam int OUT_BIT    = 12;
  localparam int SHIFT      = 8;
  localparam int TAPS       = KSIZE * KSIZE;
  localparam int NW         = OUT_CH * TAPS + OUT_CH;
  localparam int AW         = $clog2(NW);
  localparam int OMAX       = (1 << (OUT_BIT - 1)) - 1;
  localparam int OMIN       = -(1 << (OUT_BIT - 1));

  typedef struct {
    logic [OUT_CH*OUT_BIT-1:0] dat;
    bit                        last;
    int                        cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_kxk_stream_if #(.DATA_BIT(DATA_BIT), .WEIGHT_BIT(WEIGHT_BIT), .OUT_CH(OUT_CH),
                       .OUT_BIT(OUT_BIT), .AW(AW)) bus ();

  conv_kxk_stream #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_BIT(DATA_BIT), .KSIZE(KSIZE), .OUT_CH(OUT_CH),
    .WEIGHT_BIT(WEIGHT_BIT), .OUT_BIT(OUT_BIT), .SHIFT(SHIFT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t                      sb_q[$];
  int                        checks = 0;
  int                        fails  = 0;
  int                        cyc    = 0;
  int                        n_last = 0;
  int                        wmod[OUT_CH][TAPS];
  int                        bmod[OUT_CH];
  int                        img[HEIGHT][WIDTH];
  logic [OUT_CH*OUT_BIT-1:0] hold_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output for the window whose top-left pixel is (y0,x0), straight from the arithmetic rules.
  function automatic logic [OUT_CH*OUT_BIT-1:0] model_out(input int y0, input int x0);
    logic [OUT_CH*OUT_BIT-1:0] res;
    int s;
    res = '0;
    for (int ch = 0; ch < OUT_CH; ch++) begin
      s = bmod[ch];
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          s += wmod[ch][r*KSIZE+c] * img[y0+r][x0+c];
      s = s >>> SHIFT;
      if (s > OMAX) s = OMAX;
      if (s < OMIN) s = OMIN;
      res[ch*OUT_BIT +: OUT_BIT] = OUT_BIT'(s);
    end
    return res;
  endfunction

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_BIT'($urandom);
    bus.w_we     = 1'b0;
  endtask

  task automatic send(input int y, input int x);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_BIT'(img[y][x]);
    bus.w_we     = 1'b0;
    if (y >= KSIZE - 1 && x >= KSIZE - 1) begin
      e.dat  = model_out(y - KSIZE + 1, x - KSIZE + 1);
      e.last = (y == HEIGHT - 1) && (x == WIDTH - 1);
      e.cyc  = cyc + 4;
      sb_q.push_back(e);
    end
  endtask

  task automatic wr(input int addr, input int val);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.w_we     = 1'b1;
    bus.w_addr   = AW'(addr);
    bus.w_data   = WEIGHT_BIT'(val);
    if (addr < OUT_CH * TAPS) wmod[addr / TAPS][addr % TAPS] = val;
    else if (addr < NW)       bmod[addr - OUT_CH * TAPS] = val;
  endtask

  // mode 0: random weights/biases; mode 1: ch0 all 1 bias -1, ch1 all 127, ch2 all -128.
  task automatic load(input int mode);
    int v;
    for (int a = 0; a < NW; a++) begin
      if (mode == 0) v = int'($urandom_range(0, 255)) - 128;
      else if (a < OUT_CH * TAPS) v = (a / TAPS == 0) ? 1 : ((a / TAPS == 1) ? 127 : -128);
      else v = (a == OUT_CH * TAPS) ? -1 : 0;
      wr(a, v);
    end
    for (int a = NW; a < (1 << AW); a++) wr(a, int'($urandom_range(0, 255)) - 128);
    idle();
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        img[y][x] = (mode == 0) ? int'($urandom_range(0, 255)) : 255;
  endtask

  task automatic frame(input int gap_pct, input int abort_y, input int abort_x);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++) begin
        while (int'($urandom_range(0, 99)) < gap_pct) idle();
        send(y, x);
        if (y == abort_y && x == abort_x) return;
      end
  endtask

  task automatic flush();
    repeat (8) idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb_q.delete();
    hold_exp     = '0;
    bus.in_valid = 1'b0;
    bus.w_we     = 1'b0;
    for (int ch = 0; ch < OUT_CH; ch++) begin
      bmod[ch] = 0;
      for (int t = 0; t < TAPS; t++) wmod[ch][t] = 0;
    end
    #1;
    chk("rst_conv_out", longint'(bus.conv_out), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_last", longint'(bus.out_last), 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        chk("out_valid_due", longint'(bus.out_valid), 1);
        if (bus.out_valid) begin
          for (int ch = 0; ch < OUT_CH; ch++)
            chk($sformatf("conv_out_ch%0d", ch),
                longint'($signed(bus.conv_out[ch*OUT_BIT +: OUT_BIT])),
                longint'($signed(e.dat[ch*OUT_BIT +: OUT_BIT])));
          chk("out_last", longint'(bus.out_last), longint'(e.last));
          chk("latency_cycle", cyc, e.cyc);
          hold_exp = e.dat;
          if (bus.out_last) n_last++;
        end
      end else if (bus.out_valid) begin
        chk("out_valid_unexpected", 1, 0);
      end else begin
        chk("conv_out_hold", longint'(bus.conv_out), longint'(hold_exp));
        chk("out_last_idle", longint'(bus.out_last), 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.w_we     = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    for (int ch = 0; ch < OUT_CH; ch++) begin
      bmod[ch] = 0;
      for (int t = 0; t < TAPS; t++) wmod[ch][t] = 0;
    end
    repeat (3) @(negedge clk);
    chk("init_conv_out", longint'(bus.conv_out), 0);
    chk("init_out_valid", longint'(bus.out_valid), 0);
    chk("init_out_last", longint'(bus.out_last), 0);
    #2;
    rst = 1'b1;

    // Random kernels, continuous stream, then the same image back-to-back.
    load(0);
    fill(0);
    frame(0, -1, -1);
    frame(0, -1, -1);
    // New image with ~50% in_valid gaps.
    fill(0);
    frame(50, -1, -1);
    flush();
    // Saturation on ch1/ch2, bias and floor shift on ch0.
    load(1);
    fill(1);
    frame(30, -1, -1);
    flush();
    // Abort mid-frame with an asynchronous reset, then a zero-weight frame, then reload.
    load(0);
    fill(0);
    frame(0, 10, 10);
    do_reset();
    frame(0, -1, -1);
    flush();
    load(0);
    frame(20, -1, -1);
    flush();

    chk("scoreboard_empty", sb_q.size(), 0);
    chk("frames_with_last", n_last, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
